mips_irq_ctl: RTL and testbench

Device-side interrupt controller for the mips789 system. Collects up to N_SRC peripheral interrupt lines, holds them as maskable pending bits, and drives the core's single interrupt request with a vector address. The core acknowledges and ends service via word accesses on the coprocessor data bus (addr / din / mem_ctl / dout), the same bus the device block decodes. The block sits beside the device block, between peripherals and the core's irq_i / irq_addr inputs.

---
 rtl/mips_irq_ctl.sv | 142 ++++++++++++++
 tb/tb_mips_irq_ctl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_irq_ctl.sv
// Interrupt controller for the mips789 core: synchronizes peripheral lines into
// maskable pending bits and presents one vectored request, acked/ended over the cop bus.
module mips_irq_ctl #(
  parameter int          N_SRC      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_A000,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0050,
  parameter int          VEC_STRIDE = 8,
  parameter logic [3:0]  MEM_CTL_LW = 4'd1,
  parameter logic [3:0]  MEM_CTL_SW = 4'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  input  logic [3:0]       mem_ctl,
  output logic [31:0]      dout,
  input  logic [N_SRC-1:0] src_i,
  output logic             irq_req_o,
  output logic [31:0]      irq_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [4:0] OFF_PEND   = 5'h00;
  localparam logic [4:0] OFF_MASK   = 5'h04;
  localparam logic [4:0] OFF_EDGE   = 5'h08;
  localparam logic [4:0] OFF_ACTIVE = 5'h0C;
  localparam logic [4:0] OFF_EOI    = 5'h10;

  state_t           state;
  logic [3:0]       id;
  logic [N_SRC-1:0] pend, mask, edge_cfg;
  logic [N_SRC-1:0] sync1, sync2, dly;
  logic [N_SRC-1:0] pend_nxt, mask_nxt, edge_nxt, clr, rise, eligible;
  logic             in_win, rd, wr, ack, eoi, keep, found;
  logic [4:0]       offs;
  logic [3:0]       win;
  logic [31:0]      win_addr;

  assign in_win = (addr[31:5] == BASE_ADDR[31:5]);
  assign offs   = addr[4:0];
  assign rd     = in_win && (mem_ctl == MEM_CTL_LW);
  assign wr     = in_win && (mem_ctl == MEM_CTL_SW);
  assign ack    = rd && (offs == OFF_ACTIVE) && (state == REQ);
  assign eoi    = wr && (offs == OFF_EOI) && (state == SERVICE);
  assign rise   = sync2 & ~dly;

  // Edge sources accumulate (a new edge beats any clear); level sources just follow the line.
  always_comb begin
    mask_nxt = (wr && offs == OFF_MASK) ? din[N_SRC-1:0] : mask;
    edge_nxt = (wr && offs == OFF_EDGE) ? din[N_SRC-1:0] : edge_cfg;
    clr      = (wr && offs == OFF_PEND) ? din[N_SRC-1:0] : '0;
    pend_nxt = '0;
    keep     = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ack && edge_cfg[i] && (id == 4'(i))) clr[i] = 1'b1;
      pend_nxt[i] = edge_cfg[i] ? ((pend[i] & ~clr[i]) | rise[i]) : sync2[i];
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (id == 4'(i)) keep = pend_nxt[i] & mask_nxt[i];
    end
  end

  always_comb begin
    eligible = pend & mask;
    found    = |eligible;
    win      = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win = 4'(i);
    end
    win_addr = VEC_BASE + ({28'b0, win} * 32'(VEC_STRIDE));
  end

  always_comb begin
    dout = '0;
    if (rd) begin
      case (offs)
        OFF_PEND:   dout = 32'(pend);
        OFF_MASK:   dout = 32'(mask);
        OFF_EDGE:   dout = 32'(edge_cfg);
        OFF_ACTIVE: dout = {state != IDLE, 27'b0, id};
        default:    dout = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      dly      <= '0;
      pend     <= '0;
      mask     <= '0;
      edge_cfg <= '0;
    end else begin
      sync1    <= src_i;
      sync2    <= sync1;
      dly      <= sync2;
      pend     <= pend_nxt;
      mask     <= mask_nxt;
      edge_cfg <= edge_nxt;
    end
  end

  // A request is dropped if its source vanishes this edge, unless the ack lands first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      id         <= '0;
      irq_req_o  <= 1'b0;
      irq_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id         <= win;
            irq_addr_o <= win_addr;
            irq_req_o  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            irq_req_o <= 1'b0;
            state     <= SERVICE;
          end else if (!keep) begin
            irq_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          irq_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Scoreboard bench for mips_irq_ctl: expected values are queued as stimulus is
// driven and popped when the DUT response is sampled.
module tb_mips_irq_ctl;

  localparam logic [31:0] A_PEND   = 32'h0000_A000;
  localparam logic [31:0] A_MASK   = 32'h0000_A004;
  localparam logic [31:0] A_EDGE   = 32'h0000_A008;
  localparam logic [31:0] A_ACTIVE = 32'h0000_A00C;
  localparam logic [31:0] A_EOI    = 32'h0000_A010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din, dout;
  logic [3:0]  mem_ctl;
  logic [7:0]  src_i;
  logic        irq_req_o;
  logic [31:0] irq_addr_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp, got;

  mips_irq_ctl dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .mem_ctl(mem_ctl),
    .dout(dout), .src_i(src_i), .irq_req_o(irq_req_o), .irq_addr_o(irq_addr_o)
  );

  always #10 clk = ~clk;

  // Bus ops start on a negedge, sample mid-cycle, and return at the next negedge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; mem_ctl = 4'd1;
    #1 d = dout;
    @(negedge clk);
    mem_ctl = 4'd0; addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; mem_ctl = 4'd2;
    @(negedge clk);
    mem_ctl = 4'd0; addr = '0; din = '0;
  endtask

  task automatic test_reset;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_req: got %h expected %h", got, exp); errors++; end
    got = irq_addr_o; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_addr: got %h expected %h", got, exp); errors++; end
    foreach (exp_q[i]) ; // queue is empty here
    exp_q.push_back(32'h0); bus_read(A_MASK, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_mask: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0); bus_read(A_EDGE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_edge: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0); bus_read(A_PEND, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_pend: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_active: got %h expected %h", got, exp); errors++; end
  endtask

  task automatic test_edge_basic;
    bus_write(A_EDGE, 32'h01);
    bus_write(A_MASK, 32'h01);
    src_i = 8'h01;
    @(negedge clk); src_i = 8'h00;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(32'h0);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_req_early: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h1); bus_read(A_PEND, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_pend_3: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h1); exp_q.push_back(32'h50);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_req_4: got %h expected %h", got, exp); errors++; end
    got = irq_addr_o; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_vec: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h8000_0000); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_ack: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_req_fall: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0); bus_read(A_PEND, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_pend_clr: got %h expected %h", got, exp); errors++; end
    bus_write(A_EOI, 32'h0);
    exp_q.push_back(32'h0); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL edge_eoi_idle: got %h expected %h", got, exp); errors++; end
  endtask

  task automatic test_priority;
    bus_write(A_MASK, 32'hFF);
    bus_write(A_EDGE, 32'hFF);
    src_i = 8'h24;
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h1); exp_q.push_back(32'h60);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL prio_req: got %h expected %h", got, exp); errors++; end
    got = irq_addr_o; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL prio_vec2: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h8000_0002); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL prio_ack2: got %h expected %h", got, exp); errors++; end
    bus_write(A_EOI, 32'h0);
    exp_q.push_back(32'h0);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL prio_eoi_gap: got %h expected %h", got, exp); errors++; end
    @(negedge clk);
    exp_q.push_back(32'h1); exp_q.push_back(32'h78);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL prio_req5: got %h expected %h", got, exp); errors++; end
    got = irq_addr_o; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL prio_vec5: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h8000_0005); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL prio_ack5: got %h expected %h", got, exp); errors++; end
    bus_write(A_EOI, 32'h0);
    src_i = 8'h00;
  endtask

  task automatic test_level_drop;
    bus_write(A_EDGE, 32'h00);
    bus_write(A_MASK, 32'h08);
    src_i = 8'h08;
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h1); exp_q.push_back(32'h68);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL level_req: got %h expected %h", got, exp); errors++; end
    got = irq_addr_o; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL level_vec: got %h expected %h", got, exp); errors++; end
    src_i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!irq_req_o) break;
    end
    exp_q.push_back(32'h0);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL level_drop: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0000_0003); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL level_idle: got %h expected %h", got, exp); errors++; end
  endtask

  task automatic test_masked_pending;
    bus_write(A_MASK, 32'h00);
    bus_write(A_EDGE, 32'h02);
    src_i = 8'h02;
    @(negedge clk); src_i = 8'h00;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(32'h02); bus_read(A_PEND, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL masked_pend: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL masked_noreq: got %h expected %h", got, exp); errors++; end
    bus_write(A_MASK, 32'h02);
    exp_q.push_back(32'h0);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL unmask_edge1: got %h expected %h", got, exp); errors++; end
    @(negedge clk);
    exp_q.push_back(32'h1); exp_q.push_back(32'h58);
    got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL unmask_edge2: got %h expected %h", got, exp); errors++; end
    got = irq_addr_o; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL unmask_vec: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h8000_0001); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL masked_ack: got %h expected %h", got, exp); errors++; end
    // The W1C lands on the same edge that latches the new rising edge.
    src_i = 8'h02;
    @(negedge clk);
    @(negedge clk);
    bus_write(A_PEND, 32'h02);
    exp_q.push_back(32'h02); bus_read(A_PEND, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL set_wins: got %h expected %h", got, exp); errors++; end
  endtask

  task automatic test_reset_in_service;
    exp_q.push_back(32'h8000_0001); bus_read(A_ACTIVE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL svc_before_rst: got %h expected %h", got, exp); errors++; end
    #1 rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1 got = {31'b0, irq_req_o}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_req: got %h expected %h", got, exp); errors++; end
    got = irq_addr_o; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_addr: got %h expected %h", got, exp); errors++; end
    mem_ctl = 4'd1;
    exp_q.push_back(32'h0); addr = A_PEND;
    #1 got = dout; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_pend: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0); addr = A_MASK;
    #1 got = dout; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_mask: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0); addr = A_EDGE;
    #1 got = dout; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_edge: got %h expected %h", got, exp); errors++; end
    exp_q.push_back(32'h0); addr = A_ACTIVE;
    #1 got = dout; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_active: got %h expected %h", got, exp); errors++; end
    mem_ctl = 4'd0; addr = '0;
  endtask

  initial begin
    rst = 1'b0; addr = '0; din = '0; mem_ctl = 4'd0; src_i = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_edge_basic;
    test_priority;
    test_level_drop;
    test_masked_pending;
    test_reset_in_service;
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
